// File: rtl/best_root_writer_pkg.sv
// best_root_writer_pkg
// Shared definitions for the best-root writer: FSM state encoding, the
// default extended word width, and a helper that derives the extended
// word width (data bits plus flopoco exception bits) from the top-level
// parameters.
// Ports: none (package).
package best_root_writer_pkg;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        INIT    = 3'd1,
        COMPARE = 3'd2,
        WRITE   = 3'd3,
        DROP    = 3'd4
    } state_e;

    localparam int BRW_DATA_WIDTH = 32;
    localparam int BRW_EXTRA_BITS = 2;
    localparam int BRW_W          = BRW_DATA_WIDTH + BRW_EXTRA_BITS;

    function automatic int word_width(input int data_width, input int extra_bits);
        return data_width + extra_bits;
    endfunction

endpackage

// File: rtl/best_root_writer_err.sv
// err_compare
// Combinational candidate-vs-best error test on the numeric field only
// (exception bits excluded). Both fields are compared as unsigned.
// Macro: ERR_TIE_UPDATE_EN -- when defined, an equal error also counts as
// an improvement; otherwise only a strictly smaller error does.
// Ports:
//   cand  in   candidate error, DATA_WIDTH bits
//   best  in   current best error, DATA_WIDTH bits
//   take  out  1 when the candidate should replace the best
module err_compare #(
    parameter int DATA_WIDTH = 32
) (
    input  logic [DATA_WIDTH-1:0] cand,
    input  logic [DATA_WIDTH-1:0] best,
    output logic                  take
);

`ifdef ERR_TIE_UPDATE_EN
    assign take = (cand <= best);
`else
    assign take = (cand < best);
`endif

endmodule

// File: rtl/best_root_writer.sv
// best_root_writer
// Streams root vectors into the best-weights memory. An initial-guess load
// writes RAM_DEPTH words and resets the best error to all-ones; afterwards
// each candidate error is compared to the best so far and its
// NUM_UNKOWNS-word vector is either written (and the best updated) or
// consumed and discarded.
// Macro: ERR_TIE_UPDATE_EN -- equal errors count as improvements (see err_compare).
// Ports:
//   clk, rst (async, active-low)
//   init_start                    start initial-guess load (IDLE only)
//   err_valid, err_in             candidate error (IDLE only)
//   in_valid, in_data, in_ready   root-word stream
//   mem_data, mem_wr_en, mem_update_weight, mem_initial_flag
//                                 registered memory write port
//   best_err, best_updated, busy  status
//
// state   | meaning
// IDLE    | waiting for init_start or a candidate error
// INIT    | loading RAM_DEPTH initial words, flagged as initial
// COMPARE | one cycle: latched error vs best error
// WRITE   | writing NUM_UNKOWNS words of an improving vector
// DROP    | consuming NUM_UNKOWNS words of a non-improving vector
module best_root_writer
    import best_root_writer_pkg::*;
#(
    parameter int DATA_WIDTH    = 32,
    parameter int EXTRA_BITS    = 2,
    parameter int NUM_UNKOWNS   = 1,
    parameter int ADDRESS_WIDTH = 1
) (
    input  logic                                            clk,
    input  logic                                            rst,
    input  logic                                            init_start,
    input  logic                                            err_valid,
    input  logic [word_width(DATA_WIDTH, EXTRA_BITS)-1:0]   err_in,
    input  logic                                            in_valid,
    input  logic [word_width(DATA_WIDTH, EXTRA_BITS)-1:0]   in_data,
    output logic                                            in_ready,
    output logic [word_width(DATA_WIDTH, EXTRA_BITS)-1:0]   mem_data,
    output logic                                            mem_wr_en,
    output logic                                            mem_update_weight,
    output logic                                            mem_initial_flag,
    output logic [word_width(DATA_WIDTH, EXTRA_BITS)-1:0]   best_err,
    output logic                                            best_updated,
    output logic                                            busy
);

    localparam int W         = word_width(DATA_WIDTH, EXTRA_BITS);
    localparam int CNT_W     = ADDRESS_WIDTH + 1;
    localparam int RAM_DEPTH = 1 << ADDRESS_WIDTH;
    localparam logic [CNT_W-1:0] INIT_LAST = CNT_W'(RAM_DEPTH - 1);
    localparam logic [CNT_W-1:0] VEC_LAST  = CNT_W'(NUM_UNKOWNS - 1);

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [W-1:0]     err_q, err_d;
    logic [W-1:0]     best_err_q, best_err_d;
    logic [W-1:0]     mem_data_q, mem_data_d;
    logic             mem_wr_en_q, mem_wr_en_d;
    logic             upd_q, upd_d;
    logic             init_flag_q, init_flag_d;
    logic             best_upd_q, best_upd_d;
    logic             in_ready_q, in_ready_d;
    logic             busy_q, busy_d;
    logic             take;
    logic             xfer;

    err_compare #(.DATA_WIDTH(DATA_WIDTH)) u_err_compare (
        .cand (err_q[DATA_WIDTH-1:0]),
        .best (best_err_q[DATA_WIDTH-1:0]),
        .take (take)
    );

    assign xfer = in_valid && in_ready_q;

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        err_d       = err_q;
        best_err_d  = best_err_q;
        mem_data_d  = mem_data_q;
        mem_wr_en_d = 1'b0;
        upd_d       = 1'b0;
        init_flag_d = 1'b0;
        best_upd_d  = 1'b0;

        case (state_q)
            IDLE: begin
                // init_start has priority; a simultaneous error is dropped.
                if (init_start) begin
                    state_d = INIT;
                end else if (err_valid) begin
                    err_d   = err_in;
                    state_d = COMPARE;
                end
            end
            INIT: begin
                if (xfer) begin
                    mem_data_d  = in_data;
                    mem_wr_en_d = 1'b1;
                    init_flag_d = 1'b1;
                    if (cnt_q == INIT_LAST) begin
                        cnt_d      = '0;
                        best_err_d = '1;
                        state_d    = IDLE;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
            end
            COMPARE: begin
                state_d = take ? WRITE : DROP;
            end
            WRITE: begin
                if (xfer) begin
                    mem_data_d  = in_data;
                    mem_wr_en_d = 1'b1;
                    upd_d       = 1'b1;
                    if (cnt_q == VEC_LAST) begin
                        cnt_d      = '0;
                        best_err_d = err_q;
                        best_upd_d = 1'b1;
                        state_d    = IDLE;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
            end
            DROP: begin
                if (xfer) begin
                    if (cnt_q == VEC_LAST) begin
                        cnt_d   = '0;
                        state_d = IDLE;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
            end
            default: begin
                cnt_d   = '0;
                state_d = IDLE;
            end
        endcase

        // Handshake/status flops follow the next state so they line up
        // exactly with the state they describe.
        in_ready_d = (state_d == INIT) || (state_d == WRITE) || (state_d == DROP);
        busy_d     = (state_d != IDLE);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            err_q       <= '0;
            best_err_q  <= '1;
            mem_data_q  <= '0;
            mem_wr_en_q <= 1'b0;
            upd_q       <= 1'b0;
            init_flag_q <= 1'b0;
            best_upd_q  <= 1'b0;
            in_ready_q  <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            err_q       <= err_d;
            best_err_q  <= best_err_d;
            mem_data_q  <= mem_data_d;
            mem_wr_en_q <= mem_wr_en_d;
            upd_q       <= upd_d;
            init_flag_q <= init_flag_d;
            best_upd_q  <= best_upd_d;
            in_ready_q  <= in_ready_d;
            busy_q      <= busy_d;
        end
    end

    assign in_ready          = in_ready_q;
    assign mem_data          = mem_data_q;
    assign mem_wr_en         = mem_wr_en_q;
    assign mem_update_weight = upd_q;
    assign mem_initial_flag  = init_flag_q;
    assign best_err          = best_err_q;
    assign best_updated      = best_upd_q;
    assign busy              = busy_q;

endmodule
